apb_master_controller: RTL and testbench
========================================

# apb_master_controller

Single-master APB4 controller that accepts transfer requests over a valid/ready interface, decodes the target slave from the address and sequences the bus through IDLE, SETUP and ACCESS. It multiplexes PREADY/PRDATA/PSLVERR from NO_OF_SLAVES slaves and returns a one-cycle response carrying read data and error flags. It sits between the AVIP master driver-side logic (or any RTL requester) and the shared APB fabric. A wait-state watchdog ensures the requester is never hung by a slave.

## Interface
- NO_OF_SLAVES, 3, number of slaves; one PSEL bit each
- ADDRESS_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width (8, 16 or 32)
- SLAVE_REGION_BITS, 8, log2 of each slave's address window; slave index = paddr >> SLAVE_REGION_BITS
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles per transfer; 0 disables the watchdog
- pclk  in  1  APB clock; all logic on the rising edge
- preset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = WRITE, 0 = READ
- req_addr  in  ADDRESS_WIDTH  target address
- req_wdata  in  DATA_WIDTH  write data
- req_strb  in  DATA_WIDTH/8  write strobes
- req_prot  in  3  protection attributes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
- rsp_error  out  1  slave error, decode error or timeout
- rsp_timeout  out  1  watchdog abort
- psel  out  NO_OF_SLAVES  one-hot slave select
- penable, pwrite  out  1  APB enable, direction
- paddr  out  ADDRESS_WIDTH; pwdata  out  DATA_WIDTH; pstrb  out  DATA_WIDTH/8; pprot  out  3
- pready, pslverr  in  NO_OF_SLAVES  per-slave ready and error
- prdata  in  NO_OF_SLAVES*DATA_WIDTH  per-slave read data, slave 0 in the LSBs

## Operation
- States: IDLE, SETUP, ACCESS, DERR.
- req_ready = (state==IDLE) || (state==ACCESS && selected pready && !timeout). It is 0 while preset_n is low.
- Acceptance latches addr, write, wdata, strb and prot into registers that drive paddr, pwrite, pwdata and pprot. For reads, pstrb is forced to 0.
- Decode: idx = req_addr >> SLAVE_REGION_BITS.
  - If idx < NO_OF_SLAVES, go to SETUP with psel = 1<<idx.
  - Otherwise go to DERR with no psel; the bus stays idle.
- SETUP: penable=0. The next state is always ACCESS.
- ACCESS: penable=1. Only the selected slave's pready, pslverr and prdata are sampled.
  - pready=1: transfer completes. The response is registered. If a new request is accepted in this cycle, go to SETUP (back-to-back), otherwise go to IDLE and drop psel/penable.
  - pready=0: stay in ACCESS and increment the wait counter.
- Watchdog: if pready is still 0 in the TIMEOUT_CYCLES-th ACCESS cycle, abort at that edge. psel and penable drop, rsp_error=1, rsp_timeout=1, next state is IDLE.
- DERR: lasts one cycle. rsp_valid is set with rsp_error=1, then return to IDLE.
- rsp_rdata = selected prdata only for a successful read; otherwise 0. rsp_error = pslverr at completion.
- Address, control and data stay stable from SETUP through the completing ACCESS cycle. paddr/pwrite hold their last value in IDLE.

## Timing
- Reset (async assert): state=IDLE. psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_error, rsp_timeout and the wait counter all = 0.
- Request accepted at edge N:
  - SETUP during cycle N+1.
  - ACCESS from N+2.
  - Completion with zero wait states at edge N+3.
  - rsp_valid high during cycle N+3 for exactly one cycle.
- Each wait state adds one cycle of latency.
- Back-to-back: after the completing edge, psel stays asserted (possibly to a different slave) and penable=0 for one cycle. There are no IDLE cycles between transfers.
- Decode error: accepted at edge N, rsp_valid with error in cycle N+2. psel is never asserted.
- Timeout at TIMEOUT_CYCLES=16: accepted at edge N, abort edge N+18, rsp_valid in cycle N+18.
- Reset mid-transfer: all outputs clear immediately. No response is issued for the in-flight request.
- Changes to pready or pslverr on unselected slaves never affect state.

## Test plan
- Write to addr 0x0000_0104, wdata 0xDEADBEEF, strb 0xF, slave 1 ready with 0 waits: psel=3'b010 in SETUP; penable in the next cycle; rsp_valid 3 cycles after acceptance with rsp_error=0.
- Read from 0x0000_0008, slave 0 inserts 2 wait states and returns 0x1234_5678: rsp_rdata=0x12345678 at acceptance+5; pstrb=0 throughout.
- Back-to-back write to slave 0 then read from slave 2 (0x0000_0200): psel goes 001→100 with no IDLE cycle; penable low for exactly one cycle between the transfers.
- Request to 0x0000_0300 (idx 3): no psel; rsp_error=1, rsp_timeout=0, rsp_rdata=0 at acceptance+2.
- Slave 1 holds pready=0 forever: abort after 16 ACCESS cycles; rsp_error=1 and rsp_timeout=1; the controller then accepts a new request.
- preset_n asserted during ACCESS with pready low: all outputs 0 asynchronously; no rsp_valid; after release, req_ready=1 and a write completes normally.

Source files
------------

// File: rtl/apb_master_controller_if.sv
// -----------------------------------------------------------------------------
// apb_master_controller_if
// Bundles the requester handshake, the one-cycle response and the shared APB
// fabric signals of apb_master_controller.
//   master modport : the controller's view (drives req_ready, rsp_*, APB outputs)
//   slave modport  : the environment's view (requester plus APB slaves)
// Request handshake: a request transfers on a rising pclk edge where
// req_valid && req_ready; req_valid must hold its payload until then.
// The response is a single-cycle rsp_valid pulse with no back-pressure.
// -----------------------------------------------------------------------------
interface apb_master_controller_if #(
  parameter int NO_OF_SLAVES  = 3,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                                 req_valid;
  logic                                 req_ready;
  logic                                 req_write;
  logic [ADDRESS_WIDTH-1:0]             req_addr;
  logic [DATA_WIDTH-1:0]                req_wdata;
  logic [DATA_WIDTH/8-1:0]              req_strb;
  logic [2:0]                           req_prot;

  logic                                 rsp_valid;
  logic [DATA_WIDTH-1:0]                rsp_rdata;
  logic                                 rsp_error;
  logic                                 rsp_timeout;

  logic [NO_OF_SLAVES-1:0]              psel;
  logic                                 penable;
  logic                                 pwrite;
  logic [ADDRESS_WIDTH-1:0]             paddr;
  logic [DATA_WIDTH-1:0]                pwdata;
  logic [DATA_WIDTH/8-1:0]              pstrb;
  logic [2:0]                           pprot;
  logic [NO_OF_SLAVES-1:0]              pready;
  logic [NO_OF_SLAVES-1:0]              pslverr;
  logic [NO_OF_SLAVES*DATA_WIDTH-1:0]   prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  pready, pslverr, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output pready, pslverr, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );
endinterface

// File: rtl/apb_master_controller.sv
// -----------------------------------------------------------------------------
// apb_master_controller
// Single-master APB4 controller. Accepts requests over a valid/ready handshake,
// decodes the slave from the address (idx = addr >> SLAVE_REGION_BITS),
// sequences IDLE -> SETUP -> ACCESS, muxes the selected slave's
// pready/pslverr/prdata and returns a registered one-cycle response.
// Out-of-range addresses take a one-cycle DERR path without touching the bus.
// A wait-state watchdog aborts a transfer after TIMEOUT_CYCLES ACCESS cycles
// (0 disables it).
// Ports:
//   pclk      : clock, rising edge
//   preset_n  : asynchronous active-low reset
//   bus       : apb_master_controller_if.master (request, response, APB)
//   dbg_state : current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 DERR)
// -----------------------------------------------------------------------------
module apb_master_controller #(
  parameter int NO_OF_SLAVES      = 3,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int SLAVE_REGION_BITS = 8,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                   pclk,
  input  logic                   preset_n,
  apb_master_controller_if.master bus,
  output logic [1:0]             dbg_state
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DERR   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [NO_OF_SLAVES-1:0]  psel_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [STRB_W-1:0]        strb_q;
  logic [2:0]               prot_q;
  logic [WAIT_W-1:0]        wait_cnt;

  logic                     rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q;
  logic                     rsp_error_q;
  logic                     rsp_timeout_q;

  logic [ADDRESS_WIDTH-1:0] idx;
  logic                     decode_ok;
  logic [NO_OF_SLAVES-1:0]  dec_onehot;
  logic                     sel_ready;
  logic                     sel_err;
  logic [DATA_WIDTH-1:0]    sel_rdata;
  logic                     wd_hit;
  logic                     complete;
  logic                     ready_int;
  logic                     accept;

  // Address decode of the incoming request.
  always_comb begin
    idx        = bus.req_addr >> SLAVE_REGION_BITS;
    decode_ok  = idx < ADDRESS_WIDTH'(NO_OF_SLAVES);
    dec_onehot = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      dec_onehot[i] = (idx == ADDRESS_WIDTH'(i));
    end
  end

  // Only the latched selection is observed, so unselected slaves are ignored.
  always_comb begin
    sel_ready = |(bus.pready & psel_q);
    sel_err   = |(bus.pslverr & psel_q);
    sel_rdata = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      if (psel_q[i]) sel_rdata = sel_rdata | bus.prdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // wait_cnt is 0 in the first ACCESS cycle, so the TIMEOUT_CYCLES-th
  // ACCESS cycle sees TIMEOUT_CYCLES-1.
  assign wd_hit    = (TIMEOUT_CYCLES != 0) && (state == ST_ACCESS) && !sel_ready &&
                     (int'(wait_cnt) == TIMEOUT_CYCLES - 1);
  assign complete  = (state == ST_ACCESS) && sel_ready;
  assign ready_int = preset_n &&
                     ((state == ST_IDLE) || ((state == ST_ACCESS) && sel_ready && !wd_hit));
  assign accept    = bus.req_valid && ready_int;

  // FSM: state register
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = decode_ok ? ST_SETUP : ST_DERR;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (complete)    state_nxt = accept ? (decode_ok ? ST_SETUP : ST_DERR) : ST_IDLE;
        else if (wd_hit) state_nxt = ST_IDLE;
      end
      ST_DERR:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.req_ready   = ready_int;
    bus.psel        = ((state == ST_SETUP) || (state == ST_ACCESS)) ? psel_q : '0;
    bus.penable     = (state == ST_ACCESS);
    bus.pwrite      = write_q;
    bus.paddr       = addr_q;
    bus.pwdata      = wdata_q;
    bus.pstrb       = strb_q;
    bus.pprot       = prot_q;
    bus.rsp_valid   = rsp_valid_q;
    bus.rsp_rdata   = rsp_rdata_q;
    bus.rsp_error   = rsp_error_q;
    bus.rsp_timeout = rsp_timeout_q;
    dbg_state       = state;
  end

  // Request capture and wait-state counter. Strobes are zeroed for reads at
  // capture time so pstrb is 0 for the whole read transfer.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      psel_q   <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prot_q   <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        psel_q  <= decode_ok ? dec_onehot : '0;
        addr_q  <= bus.req_addr;
        write_q <= bus.req_write;
        wdata_q <= bus.req_wdata;
        strb_q  <= bus.req_write ? bus.req_strb : '0;
        prot_q  <= bus.req_prot;
      end
      if ((state == ST_ACCESS) && !sel_ready && !wd_hit) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                                wait_cnt <= '0;
    end
  end

  // Registered one-cycle response.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      if (complete) begin
        rsp_valid_q <= 1'b1;
        rsp_error_q <= sel_err;
        rsp_rdata_q <= (!write_q && !sel_err) ? sel_rdata : '0;
      end else if (wd_hit) begin
        rsp_valid_q   <= 1'b1;
        rsp_error_q   <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end else if (state == ST_DERR) begin
        rsp_valid_q <= 1'b1;
        rsp_error_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_controller.sv
// -----------------------------------------------------------------------------
// tb_apb_master_controller
// Bench for apb_master_controller: configurable per-slave model (wait states,
// hang, error, read data, random pready/pslverr noise on unselected slaves),
// request driver task, response scoreboard with an expected queue.
// -----------------------------------------------------------------------------
module tb_apb_master_controller;

  localparam int NS = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 pclk = ~pclk;

  apb_master_controller_if #(.NO_OF_SLAVES(NS), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_controller #(
    .NO_OF_SLAVES(NS), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
    .SLAVE_REGION_BITS(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk      (pclk),
    .preset_n  (preset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // scoreboard entry: {expected cycle[15:0], error, timeout, rdata[31:0]}
  logic [49:0] exp_q[$];
  logic [49:0] mon_e;

  // ---------------- slave model ----------------
  int              waits   [NS];
  logic            hang    [NS];
  logic            err_cfg [NS];
  logic [DW-1:0]   rd_data [NS];
  int              cnt     [NS];
  logic [NS-1:0]   noise_rdy = '0;
  logic [NS-1:0]   noise_err = '0;

  always @(posedge pclk) begin
    cyc       <= cyc + 1;
    noise_rdy <= NS'($urandom);
    noise_err <= NS'($urandom);
    for (int i = 0; i < NS; i++) begin
      if (bus.psel[i] && bus.penable && !bus.pready[i]) cnt[i] <= cnt[i] + 1;
      else                                              cnt[i] <= 0;
    end
  end

  always_comb begin
    bus.pready  = '0;
    bus.pslverr = '0;
    bus.prdata  = '0;
    for (int i = 0; i < NS; i++) begin
      if (bus.psel[i] && bus.penable) begin
        bus.pready[i]  = !hang[i] && (cnt[i] == waits[i]);
        bus.pslverr[i] = err_cfg[i];
      end else begin
        bus.pready[i]  = noise_rdy[i];
        bus.pslverr[i] = noise_err[i];
      end
      bus.prdata[i*DW +: DW] = rd_data[i];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge pclk) begin
    if (preset_n && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_cycle",   64'(cyc[15:0]),        64'(mon_e[49:34]));
        check("rsp_error",   64'(bus.rsp_error),    64'(mon_e[33]));
        check("rsp_timeout", 64'(bus.rsp_timeout),  64'(mon_e[32]));
        check("rsp_rdata",   64'(bus.rsp_rdata),    64'(mon_e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a request, waits for acceptance, pushes the expected response
  // (lat = cycles from the accepting edge to the rsp_valid cycle), then checks
  // the SETUP cycle and optionally the first ACCESS cycle. Returns with
  // req_valid low, at the negedge of the SETUP (or ACCESS) cycle.
  task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [3:0] strb, input logic exp_err, input logic exp_to,
                        input logic [DW-1:0] exp_rd, input int lat, input bit chk_access,
                        input bit push);
    int n;
    int k;
    logic [AW-1:0] idx;
    logic [NS-1:0] exp_psel;
    logic [2:0]    prot;
    idx      = addr >> 8;
    exp_psel = (idx < AW'(NS)) ? (NS'(1) << idx) : '0;
    prot     = 3'($urandom);
    @(negedge pclk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    bus.req_prot  = prot;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(negedge pclk);
      n++;
    end
    if (!bus.req_ready) begin
      check("req_accept", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    k = cyc;
    if (push) exp_q.push_back({16'(k + lat), exp_err, exp_to, exp_rd});
    @(negedge pclk);
    bus.req_valid = 1'b0;
    check("setup_psel",    64'(bus.psel),    64'(exp_psel));
    check("setup_penable", 64'(bus.penable), 64'd0);
    if (exp_psel != '0) begin
      check("setup_paddr",  64'(bus.paddr),  64'(addr));
      check("setup_pwrite", 64'(bus.pwrite), 64'(wr));
      check("setup_pstrb",  64'(bus.pstrb),  wr ? 64'(strb) : 64'd0);
      check("setup_pprot",  64'(bus.pprot),  64'(prot));
      if (wr) check("setup_pwdata", 64'(bus.pwdata), 64'(wdata));
      if (chk_access) begin
        @(negedge pclk);
        check("access_psel",    64'(bus.psel),    64'(exp_psel));
        check("access_penable", 64'(bus.penable), 64'd1);
        check("access_paddr",   64'(bus.paddr),   64'(addr));
        check("access_pstrb",   64'(bus.pstrb),   wr ? 64'(strb) : 64'd0);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge pclk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("rsp_missing", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(negedge pclk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    logic wr;
    logic [AW-1:0] a;
    logic [3:0] st;
    logic [DW-1:0] wd;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.req_prot  = '0;
    for (int i = 0; i < NS; i++) begin
      waits[i] = 0; hang[i] = 1'b0; err_cfg[i] = 1'b0;
    end
    rd_data[0] = 32'hA0A0_0000;
    rd_data[1] = 32'hB1B1_1111;
    rd_data[2] = 32'hC2C2_2222;

    repeat (3) @(negedge pclk);
    check("rst_req_ready", 64'(bus.req_ready),  64'd0);
    check("rst_psel",      64'(bus.psel),       64'd0);
    check("rst_penable",   64'(bus.penable),    64'd0);
    check("rst_paddr",     64'(bus.paddr),      64'd0);
    check("rst_pwrite",    64'(bus.pwrite),     64'd0);
    check("rst_pwdata",    64'(bus.pwdata),     64'd0);
    check("rst_pstrb",     64'(bus.pstrb),      64'd0);
    check("rst_pprot",     64'(bus.pprot),      64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid),  64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata),  64'd0);
    check("rst_state",     64'(dbg_state),      64'd0);
    preset_n = 1'b1;
    @(negedge pclk);
    check("idle_req_ready", 64'(bus.req_ready), 64'd1);

    // write to slave 1, zero wait states
    do_req(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, '0, 3, 1'b1, 1'b1);
    drain();

    // read from slave 0 with 2 wait states
    waits[0] = 2; rd_data[0] = 32'h1234_5678;
    do_req(1'b0, 32'h0000_0008, 32'h5555_AAAA, 4'hF, 1'b0, 1'b0, 32'h1234_5678, 5, 1'b1, 1'b1);
    drain();
    waits[0] = 0;

    // back-to-back: write slave 0 then read slave 2, no IDLE in between
    do_req(1'b1, 32'h0000_0004, 32'h0BAD_F00D, 4'h3, 1'b0, 1'b0, '0, 3, 1'b0, 1'b1);
    do_req(1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b0, 1'b0, 32'hC2C2_2222, 3, 1'b1, 1'b1);
    drain();

    // decode error (idx 3)
    do_req(1'b0, 32'h0000_0300, 32'h0, 4'hF, 1'b1, 1'b0, '0, 2, 1'b0, 1'b1);
    drain();

    // slave error on a read, data must be suppressed
    err_cfg[2] = 1'b1; waits[2] = 1;
    do_req(1'b0, 32'h0000_0210, 32'h0, 4'hF, 1'b1, 1'b0, '0, 4, 1'b1, 1'b1);
    drain();
    err_cfg[2] = 1'b0; waits[2] = 0;

    // watchdog: slave 1 never ready
    hang[1] = 1'b1;
    do_req(1'b0, 32'h0000_01F0, 32'h0, 4'hF, 1'b1, 1'b1, '0, TO + 2, 1'b1, 1'b1);
    drain();
    hang[1] = 1'b0;
    do_req(1'b1, 32'h0000_0100, 32'h7777_0001, 4'h5, 1'b0, 1'b0, '0, 3, 1'b1, 1'b1);
    drain();

    // random transfers
    for (int t = 0; t < 12; t++) begin
      s  = $urandom_range(0, NS - 1);
      waits[s]   = $urandom_range(0, 3);
      err_cfg[s] = 1'($urandom_range(0, 1));
      rd_data[s] = $urandom;
      wr = 1'($urandom_range(0, 1));
      a  = (AW'(s) << 8) | (AW'($urandom_range(0, 63)) << 2);
      st = 4'($urandom_range(0, 15));
      wd = $urandom;
      do_req(wr, a, wd, st, err_cfg[s], 1'b0, (!wr && !err_cfg[s]) ? rd_data[s] : '0,
             3 + waits[s], 1'b1, 1'b1);
      drain();
      waits[s] = 0; err_cfg[s] = 1'b0;
    end

    // reset during ACCESS with pready low: no response for the in-flight request
    hang[2] = 1'b1;
    do_req(1'b0, 32'h0000_0220, 32'h0, 4'hF, 1'b0, 1'b0, '0, 0, 1'b1, 1'b0);
    @(negedge pclk);
    #2 preset_n = 1'b0;
    #1;
    check("midrst_psel",      64'(bus.psel),      64'd0);
    check("midrst_penable",   64'(bus.penable),   64'd0);
    check("midrst_paddr",     64'(bus.paddr),     64'd0);
    check("midrst_pstrb",     64'(bus.pstrb),     64'd0);
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    check("midrst_state",     64'(dbg_state),     64'd0);
    @(negedge pclk);
    hang[2] = 1'b0;
    preset_n = 1'b1;
    @(negedge pclk);
    check("postrst_req_ready", 64'(bus.req_ready), 64'd1);
    do_req(1'b1, 32'h0000_0230, 32'hCAFE_0123, 4'hF, 1'b0, 1'b0, '0, 3, 1'b1, 1'b1);
    drain();
    repeat (4) @(negedge pclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #300000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
